// File: rtl/fixed_series_eval.sv
// Truncated Taylor-series evaluator for exp(x)/cos(x) in signed Q(W-FRAC).FRAC, Horner form.
// Optional build macro FIXED_SERIES_TRUNC_EN: mulq truncates instead of rounding to nearest.
module fixed_series_eval #(
  parameter int W       = 32,
  parameter int FRAC    = 28,
  parameter int N_TERMS = 7
) (
  input  logic         clk,
  input  logic         res,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] x_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int CW = $clog2(N_TERMS);
  localparam logic [W-1:0] MAXW = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINW = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] MAX2 = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MIN2 = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SQR, ITER, FIN} state_t;

  // Factorials beyond 2^(FRAC+2) always round to a zero coefficient, so stop
  // accumulating there to keep the arithmetic inside 64 bits.
  function automatic logic [W-1:0] coef(input int unsigned k, input bit is_cos);
    longint unsigned f, lim, q;
    int unsigned     n;
    bit              big;
    f   = 64'd1;
    big = 1'b0;
    lim = 64'd1 << (FRAC + 2);
    n   = is_cos ? 2 * k : k;
    for (int unsigned i = 2; i <= n; i++) begin
      if (!big) begin
        f = f * 64'(i);
        if (f > lim) big = 1'b1;
      end
    end
    q    = big ? 64'd0 : (((64'd1 << FRAC) + f / 2) / f);
    coef = W'(q);
    if (is_cos && k[0]) coef = -coef;
  endfunction

  logic [W-1:0] rom_exp [N_TERMS];
  logic [W-1:0] rom_cos [N_TERMS];

  for (genvar g = 0; g < N_TERMS; g++) begin : g_rom
    assign rom_exp[g] = coef(g, 1'b0);
    assign rom_cos[g] = coef(g, 1'b1);
  end

  state_t         state, state_nxt;
  logic [W-1:0]   acc, x_reg, op_a, mq, c_sel, acc_nxt;
  logic [CW-1:0]  cnt;
  logic           mode_reg, ovf_int, mq_sat, add_sat;
  logic signed [2*W-1:0] a_ext, b_ext, prod, prod_r, shf;
  logic [W:0]     sum;

`ifndef FIXED_SERIES_TRUNC_EN
  localparam logic signed [2*W-1:0] RND = (2*W)'(1) << (FRAC - 1);
`endif

  // Shared multiplier: squares x in SQR, multiplies acc by x in ITER.
  always_comb begin
    op_a  = (state == SQR) ? x_reg : acc;
    a_ext = {{W{op_a[W-1]}}, op_a};
    b_ext = {{W{x_reg[W-1]}}, x_reg};
    prod  = a_ext * b_ext;
`ifdef FIXED_SERIES_TRUNC_EN
    prod_r = prod;
`else
    prod_r = prod + RND;
`endif
    shf     = prod_r >>> FRAC;
    mq_sat  = (shf > MAX2) || (shf < MIN2);
    mq      = mq_sat ? (shf[2*W-1] ? MINW : MAXW) : shf[W-1:0];
    c_sel   = mode_reg ? rom_cos[cnt] : rom_exp[cnt];
    sum     = {mq[W-1], mq} + {c_sel[W-1], c_sel};
    add_sat = sum[W] ^ sum[W-1];
    acc_nxt = add_sat ? (sum[W] ? MINW : MAXW) : sum[W-1:0];
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = mode ? SQR : ITER;
      SQR: begin
        busy      = 1'b1;
        state_nxt = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      x_reg    <= '0;
      mode_reg <= 1'b0;
      ovf_int  <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          x_reg    <= x_in;
          mode_reg <= mode;
          acc      <= mode ? rom_cos[N_TERMS-1] : rom_exp[N_TERMS-1];
          cnt      <= CW'(N_TERMS - 2);
          ovf_int  <= 1'b0;
        end
        SQR: begin
          x_reg   <= mq;
          ovf_int <= ovf_int | mq_sat;
        end
        ITER: begin
          acc     <= acc_nxt;
          ovf_int <= ovf_int | mq_sat | add_sat;
          // Result is latched on the last Horner step so it is valid in the FIN cycle.
          if (cnt == '0) begin
            result <= acc_nxt;
            ovf    <= ovf_int | mq_sat | add_sat;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_series_eval.sv
// Directed bench for fixed_series_eval at W=32, FRAC=28, N_TERMS=7.
module tb_fixed_series_eval;

  localparam int W = 32;
  localparam logic [W-1:0] ONE = 32'h1000_0000;
  localparam logic [W-1:0] E1  = 32'd729622483;

  logic         clk = 1'b0;
  logic         res, start, mode, busy, done, ovf;
  logic [W-1:0] x_in, result;
  int           total = 0;
  int           bad   = 0;

  fixed_series_eval #(.W(32), .FRAC(28), .N_TERMS(7)) dut (
    .clk(clk), .res(res), .start(start), .mode(mode), .x_in(x_in),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic m, input logic [W-1:0] x);
    start = 1'b1;
    mode  = m;
    x_in  = x;
    step();
    start = 1'b0;
    x_in  = '0;
  endtask

  // n counts edges from the accept edge (n0 already elapsed) until done is seen.
  task automatic wait_done(input string tag, input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, W'(busy), 1);
      step();
      n++;
    end
    chk({tag, "_done"}, W'(done), 1);
    chk({tag, "_busy_at_done"}, W'(busy), 0);
  endtask

  task automatic run(input string tag, input logic m, input logic [W-1:0] x, input int lat,
                     output logic [W-1:0] r, output logic o);
    int n;
    launch(m, x);
    wait_done(tag, 1, n);
    chk({tag, "_latency"}, W'(n), W'(lat));
    r = result;
    o = ovf;
    step();
    chk({tag, "_done_low"}, W'(done), 0);
  endtask

  initial begin
    logic [W-1:0] r;
    logic         o;
    int           n, dcount;
    longint       diff;

    res = 1'b1; start = 1'b0; mode = 1'b0; x_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", W'(ovf), 0);
    res = 1'b0;
    step();

    run("exp0", 1'b0, '0, 7, r, o);
    chk("exp0_result", r, ONE);
    chk("exp0_ovf", W'(o), 0);

    run("exp1", 1'b0, ONE, 7, r, o);
    chk("exp1_result", r, E1);
    chk("exp1_ovf", W'(o), 0);

    run("cos1", 1'b1, ONE, 8, r, o);
    diff = longint'($signed(r)) - 64'sd145036296;
    if (diff < 0) diff = -diff;
    total++;
    assert (diff <= 8) else begin
      bad++;
      $error("FAIL cos1_result observed=%0d expected=145036296+-8", $signed(r));
    end
    chk("cos1_ovf", W'(o), 0);

    run("cos0", 1'b1, '0, 8, r, o);
    chk("cos0_result", r, ONE);

    run("sat", 1'b0, 32'h7800_0000, 7, r, o);
    chk("sat_result", r, 32'h7FFF_FFFF);
    chk("sat_ovf", W'(o), 1);

    // result/ovf hold from the saturating run while the next one is in flight
    launch(1'b0, '0);
    step();
    chk("hold_result", result, 32'h7FFF_FFFF);
    chk("hold_ovf", W'(ovf), 1);
    wait_done("after_sat", 2, n);
    chk("after_sat_latency", W'(n), 7);
    chk("after_sat_result", result, ONE);
    chk("after_sat_ovf", W'(ovf), 0);
    step();

    // start while busy is ignored
    launch(1'b0, ONE);
    step();
    start = 1'b1; mode = 1'b1; x_in = 32'h0400_0000;
    step();
    start = 1'b0; mode = 1'b0; x_in = '0;
    wait_done("busy_start", 3, n);
    chk("busy_start_latency", W'(n), 7);
    chk("busy_start_result", result, E1);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    chk("busy_start_single_done", W'(dcount), 0);
    chk("busy_start_idle", W'(busy), 0);

    // start during FIN is ignored; held into the following IDLE cycle it is accepted
    launch(1'b0, '0);
    wait_done("fin_a", 1, n);
    start = 1'b1; mode = 1'b0; x_in = ONE;
    step();
    chk("fin_start_ignored_busy", W'(busy), 0);
    chk("fin_start_ignored_done", W'(done), 0);
    chk("fin_start_result_held", result, ONE);
    step();
    start = 1'b0; x_in = '0;
    wait_done("fin_b", 1, n);
    chk("fin_b_latency", W'(n), 7);
    chk("fin_b_result", result, E1);
    step();

    // reset in the middle of an evaluation
    launch(1'b0, ONE);
    step();
    step();
    res = 1'b1;
    step();
    res = 1'b0;
    chk("midrst_busy", W'(busy), 0);
    chk("midrst_done", W'(done), 0);
    chk("midrst_result", result, 0);
    chk("midrst_ovf", W'(ovf), 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    chk("midrst_no_done", W'(dcount), 0);

    run("post_rst", 1'b0, '0, 7, r, o);
    chk("post_rst_result", r, ONE);
    chk("post_rst_ovf", W'(o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
